// File: rtl/req_arbiter.sv
// Request arbiter with fixed-priority or round-robin selection, bounded grant tenure,
// and a mandatory one-cycle recovery gap between consecutive grants.
module req_arbiter #(
    parameter int N_REQ   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic                       i_release,
    input  logic                       i_mode,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [$clog2(N_REQ)-1:0]   o_gnt_id,
    output logic                       o_gnt_valid,
    output logic                       o_timeout_evt,
    output logic [7:0]                 o_grant_cnt
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDW-1:0]     r_gnt_id;
    logic [IDW-1:0]     r_last;
    logic               r_gnt_valid;
    logic               r_timeout_evt;
    logic [7:0]         r_grant_cnt;
    logic [3:0]         r_tenure;

    logic [N_REQ-1:0]   w_req_rot;
    logic [IDW-1:0]     w_fp_id;
    logic [IDW-1:0]     w_rr_off;
    logic [IDW-1:0]     w_rr_id;
    logic [IDW-1:0]     w_win_id;
    logic               w_hold_req;
    logic               w_tenure_max;
    logic               w_exit;

    // Requests rotated so bit 0 is the requester just after the previous holder.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [IDW-1:0] w_src;
        assign w_src          = r_last + IDW'(1) + IDW'(gi);
        assign w_req_rot[gi]  = i_req[w_src];
    end

    always_comb begin
        w_fp_id  = '0;
        w_rr_off = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_req[i]) w_fp_id = IDW'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) w_rr_off = IDW'(i);
        end
    end

    assign w_rr_id      = r_last + IDW'(1) + w_rr_off;
    assign w_win_id     = i_mode ? w_rr_id : w_fp_id;
    assign w_hold_req   = i_req[r_gnt_id];
    assign w_tenure_max = (r_tenure == 4'(TIMEOUT));
    assign w_exit       = i_release | ~w_hold_req | w_tenure_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_gnt_id      <= '0;
            r_gnt_valid   <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_grant_cnt   <= 8'd0;
            r_tenure      <= 4'd0;
            r_last        <= IDW'(N_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout_evt <= 1'b0;
                    if (|i_req) begin
                        r_state     <= GRANT;
                        r_gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win_id;
                        r_gnt_id    <= w_win_id;
                        r_gnt_valid <= 1'b1;
                        r_tenure    <= 4'd1;
                        if (r_grant_cnt != 8'hFF) r_grant_cnt <= r_grant_cnt + 8'd1;
                    end
                end
                GRANT: begin
                    if (w_exit) begin
                        r_state       <= RECOVER;
                        r_gnt         <= '0;
                        r_gnt_valid   <= 1'b0;
                        // Timeout is only reported when nothing else would have ended the tenure.
                        r_timeout_evt <= w_tenure_max & ~i_release & w_hold_req;
                        r_last        <= r_gnt_id;
                    end else begin
                        r_tenure <= r_tenure + 4'd1;
                    end
                end
                RECOVER: begin
                    r_timeout_evt <= 1'b0;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt         = r_gnt;
    assign o_gnt_id      = r_gnt_id;
    assign o_gnt_valid   = r_gnt_valid;
    assign o_timeout_evt = r_timeout_evt;
    assign o_grant_cnt   = r_grant_cnt;
endmodule

// File: tb/tb_req_arbiter.sv
// Drives two arbiters (TIMEOUT=15 and TIMEOUT=1) with shared stimulus and checks
// every cycle against a transaction-level model of the arbitration rules.
module tb_req_arbiter;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic       mode = 1'b0;

    logic [7:0] gnt_o       [2];
    logic [2:0] gnt_id_o    [2];
    logic       gnt_valid_o [2];
    logic       evt_o       [2];
    logic [7:0] cnt_o       [2];

    int checks   = 0;
    int failures = 0;

    // Model state per instance
    int tmo    [2] = '{15, 1};
    bit m_busy [2];
    bit m_cool [2];
    bit m_evt  [2];
    int m_h    [2];
    int m_age  [2];
    int m_last [2];
    int m_cnt  [2];

    always #5 clk = ~clk;

    req_arbiter #(.N_REQ(8), .TIMEOUT(15)) u_dut0 (
        .clk(clk), .rst(rst), .i_req(req), .i_release(rel), .i_mode(mode),
        .o_gnt(gnt_o[0]), .o_gnt_id(gnt_id_o[0]), .o_gnt_valid(gnt_valid_o[0]),
        .o_timeout_evt(evt_o[0]), .o_grant_cnt(cnt_o[0])
    );

    req_arbiter #(.N_REQ(8), .TIMEOUT(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_req(req), .i_release(rel), .i_mode(mode),
        .o_gnt(gnt_o[1]), .o_gnt_id(gnt_id_o[1]), .o_gnt_valid(gnt_valid_o[1]),
        .o_timeout_evt(evt_o[1]), .o_grant_cnt(cnt_o[1])
    );

    function automatic int winner(logic [7:0] r, bit md, int last);
        int  w;
        bit  found;
        w = 0;
        found = 0;
        if (!md) begin
            for (int i = N - 1; i >= 0; i--)
                if (!found && r[i]) begin found = 1; w = i; end
        end else begin
            for (int d = 1; d <= N; d++)
                if (!found && r[(last + d) % N]) begin found = 1; w = (last + d) % N; end
        end
        return w;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_upd(int k, bit rs, logic [7:0] rq, bit rl, bit md);
        bit fin;
        if (rs) begin
            m_busy[k] = 0; m_cool[k] = 0; m_evt[k] = 0;
            m_h[k] = 0; m_age[k] = 0; m_last[k] = N - 1; m_cnt[k] = 0;
        end else if (m_busy[k]) begin
            fin = rl || !rq[m_h[k]] || (m_age[k] == tmo[k]);
            if (fin) begin
                m_evt[k]  = (m_age[k] == tmo[k]) && !rl && rq[m_h[k]];
                m_busy[k] = 0;
                m_cool[k] = 1;
                m_last[k] = m_h[k];
            end else begin
                m_age[k]++;
                m_evt[k] = 0;
            end
        end else if (m_cool[k]) begin
            m_cool[k] = 0;
            m_evt[k]  = 0;
        end else begin
            m_evt[k] = 0;
            if (rq != 8'h00) begin
                m_h[k]    = winner(rq, md, m_last[k]);
                m_busy[k] = 1;
                m_age[k]  = 1;
                if (m_cnt[k] < 255) m_cnt[k]++;
            end
        end
    endtask

    task automatic step(bit rs, logic [7:0] rq, bit rl, bit md);
        logic [7:0] eg;
        rst = rs; req = rq; rel = rl; mode = md;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_upd(k, rs, rq, rl, md);
        #1;
        for (int k = 0; k < 2; k++) begin
            eg = m_busy[k] ? (8'h01 << m_h[k]) : 8'h00;
            check($sformatf("gnt[%0d]", k), 32'(gnt_o[k]), 32'(eg));
            check($sformatf("valid[%0d]", k), 32'(gnt_valid_o[k]), 32'(m_busy[k]));
            check($sformatf("evt[%0d]", k), 32'(evt_o[k]), 32'(m_evt[k]));
            check($sformatf("cnt[%0d]", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
            if (m_busy[k]) check($sformatf("gnt_id[%0d]", k), 32'(gnt_id_o[k]), 32'(m_h[k]));
        end
    endtask

    initial begin
        int         ids [$];
        int         hi;
        bit         prev;
        logic [7:0] rq;

        // Reset and the first cycle after release of reset
        step(1, 8'h00, 0, 0);
        step(1, 8'h00, 0, 0);
        check("rst_gnt_id", 32'(gnt_id_o[0]), 32'd0);
        step(0, 8'h00, 0, 0);
        check("post_rst_cnt", 32'(cnt_o[0]), 32'd0);

        // Fixed priority, release on third grant cycle
        step(0, 8'h25, 0, 0);
        check("fp_gnt", 32'(gnt_o[0]), 32'h20);
        check("fp_id", 32'(gnt_id_o[0]), 32'd5);
        step(0, 8'h25, 0, 0);
        step(0, 8'h25, 0, 0);
        step(0, 8'h25, 1, 0);
        check("fp_recover_gnt", 32'(gnt_o[0]), 32'h00);
        step(0, 8'h25, 0, 0);
        step(0, 8'h25, 0, 0);
        check("fp_regrant", 32'(gnt_o[0]), 32'h20);
        for (int t = 0; t < 4; t++) step(0, 8'h00, 0, 0);

        // Round-robin ordering from reset
        step(1, 8'h00, 0, 1);
        prev = 0;
        for (int t = 0; t < 40 && ids.size() < 9; t++) begin
            step(0, 8'hFF, 1, 1);
            if (gnt_valid_o[0] && !prev) ids.push_back(int'(gnt_id_o[0]));
            prev = gnt_valid_o[0];
        end
        check("rr_grants", 32'(ids.size()), 32'd9);
        foreach (ids[i]) check($sformatf("rr_order%0d", i), 32'(ids[i]), 32'(i % 8));
        check("rr_cnt", 32'(cnt_o[0]), 32'd9);

        // Full-length tenure ending in timeout
        step(1, 8'h00, 0, 0);
        step(0, 8'h04, 0, 0);
        hi = 0;
        for (int t = 0; t < 30 && gnt_valid_o[0]; t++) begin
            hi++;
            step(0, 8'h04, 0, 0);
        end
        check("tmo_len", 32'(hi), 32'd15);
        check("tmo_evt", 32'(evt_o[0]), 32'd1);
        step(0, 8'h04, 0, 0);
        check("tmo_evt_clear", 32'(evt_o[0]), 32'd0);
        step(0, 8'h04, 0, 0);
        check("tmo_regrant", 32'(gnt_o[0]), 32'h04);

        // Release coincident with the timeout limit
        step(1, 8'h00, 0, 0);
        step(0, 8'h04, 0, 0);
        for (int t = 0; t < 14; t++) step(0, 8'h04, 0, 0);
        step(0, 8'h04, 1, 0);
        check("tmo_rel_valid", 32'(gnt_valid_o[0]), 32'd0);
        check("tmo_rel_evt", 32'(evt_o[0]), 32'd0);

        // Reset in the middle of a grant
        step(1, 8'h00, 0, 0);
        step(0, 8'h08, 0, 0);
        check("mid_id", 32'(gnt_id_o[0]), 32'd3);
        step(1, 8'hFF, 0, 1);
        check("mid_rst_gnt", 32'(gnt_o[0]), 32'h00);
        check("mid_rst_cnt", 32'(cnt_o[0]), 32'd0);
        step(0, 8'hFF, 0, 1);
        step(0, 8'hFF, 0, 1);
        check("mid_first_rr", 32'(gnt_id_o[0]), 32'd0);

        // Holder drops its request
        step(1, 8'h00, 0, 0);
        step(0, 8'h30, 0, 0);
        step(0, 8'h10, 0, 0);
        check("drop_valid", 32'(gnt_valid_o[0]), 32'd0);
        check("drop_evt", 32'(evt_o[0]), 32'd0);

        // Counter saturation over >300 short grants
        step(1, 8'h00, 0, 0);
        for (int t = 0; t < 950; t++) step(0, 8'hFF, 1, bit'($urandom_range(0, 1)));
        check("sat_cnt0", 32'(cnt_o[0]), 32'd255);
        check("sat_cnt1", 32'(cnt_o[1]), 32'd255);

        // Random traffic
        step(1, 8'h00, 0, 0);
        for (int t = 0; t < 500; t++) begin
            rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(bit'($urandom_range(0, 63) == 0), rq,
                 bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter N_REQ, default 8, SHALL set the number of requesters (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum grant tenure in cycles (range 1..15).
REQ-003 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 req  in  N_REQ  SHALL carry request lines, one per requester; a requester holds its line high until served.
REQ-006 release  in  1  SHALL be asserted by the current holder for one or more cycles to end its tenure.
REQ-007 mode  in  1  SHALL select the arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-008 gnt  out  N_REQ  SHALL be the registered grant, one-hot or all-zero.
REQ-009 gnt_id  out  log2(N_REQ)  SHALL be the registered index of the current holder, valid when gnt_valid=1.
REQ-010 gnt_valid  out  1  SHALL be registered and high exactly when gnt is non-zero.
REQ-011 timeout_evt  out  1  SHALL be a registered one-cycle pulse marking a forced revocation.
REQ-012 grant_cnt  out  8  SHALL be a registered, saturating count of grants issued since reset.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT, RECOVER.
REQ-014 In IDLE with req == 0, the FSM SHALL remain in IDLE with gnt = 0.
REQ-015 In IDLE with req != 0, the FSM SHALL select a winner from req and mode sampled at that edge, then enter GRANT; gnt, gnt_id and gnt_valid SHALL assert on the next cycle (latency of 1 clock from sampled request).
REQ-016 With mode = 0, the winner SHALL be the highest-indexed asserted request (bit N_REQ-1 highest priority).
REQ-017 With mode = 1, the search SHALL start at index (last+1) mod N_REQ and ascend with wrap-around; the first asserted request wins; last is the index of the most recent holder.
REQ-018 mode SHALL be sampled only in IDLE; a change of mode during GRANT or RECOVER SHALL have no effect until the next IDLE evaluation.
REQ-019 On entering GRANT, a 4-bit tenure counter SHALL load 1 and increment each further cycle in GRANT.
REQ-020 GRANT SHALL exit to RECOVER when any of the following holds: release = 1, req[gnt_id] = 0 (request dropped), or tenure counter == TIMEOUT.
REQ-021 timeout_evt SHALL pulse for one cycle, coincident with the first RECOVER cycle, only when the exit cause is the timeout alone; a simultaneous release or drop SHALL suppress it.
REQ-022 With TIMEOUT = 1, every grant SHALL last exactly one cycle.
REQ-023 In RECOVER, gnt SHALL be 0 and gnt_valid SHALL be 0 for exactly one cycle, last SHALL update to the released index, and the FSM SHALL return to IDLE.
REQ-024 Back-to-back grants SHALL therefore be separated by at least two cycles with gnt = 0 (RECOVER plus IDLE).
REQ-025 grant_cnt SHALL increment on each IDLE->GRANT transition and saturate at 255.
REQ-026 Requests arriving or dropping outside IDLE, other than the holder's own line, SHALL NOT affect the current grant.

Reset
REQ-027 While rst = 1 at a clock edge, the FSM SHALL enter IDLE; gnt = 0, gnt_id = 0, gnt_valid = 0, timeout_evt = 0, grant_cnt = 0, tenure counter = 0, last = N_REQ-1.
REQ-028 Reset asserted mid-GRANT SHALL drop gnt on the following cycle, with no timeout_evt and no RECOVER cycle.
REQ-029 Outputs during the first cycle after rst deasserts SHALL equal their reset values.

Verification
REQ-030 mode=0, req=8'b0010_0101 held, release pulsed on the 3rd grant cycle -> gnt=8'b0010_0000 and gnt_id=5 one cycle after the request; gnt=0 for the RECOVER cycle, then re-arbitration.
REQ-031 mode=1, req=8'hFF held, release asserted every grant cycle from reset -> grant order 0,1,2,...,7,0 with gnt_id wrapping 7->0; grant_cnt=9 after the 9th grant.
REQ-032 TIMEOUT=15, req=8'b0000_0100, release never asserted -> gnt high for exactly 15 cycles, timeout_evt pulses one cycle, gnt=0, then re-grant to index 2.
REQ-033 Release asserted on the same cycle the tenure counter reaches TIMEOUT -> exit to RECOVER with timeout_evt=0.
REQ-034 rst asserted during GRANT with gnt_id=3 -> next cycle gnt=0, grant_cnt=0, timeout_evt=0; after release of reset with mode=1 and req=8'hFF, the first grant goes to index 0.
REQ-035 Holder drops req[gnt_id] while release=0 -> RECOVER next cycle, timeout_evt=0; 300 single-cycle grants -> grant_cnt saturates at 255.
